// File: rtl/fetch_sequencer_pkg.sv
// Shared types and opcode-bit positions for the fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned STORE_BIT   = 15;
  localparam int unsigned FLOW_BIT    = 14;
  localparam int unsigned CORESEL_BIT = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Flow-control encodings of {STORE_BIT, FLOW_BIT}.
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b11;

endpackage

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Program-counter next-value mux: call target, return address or modulo increment.
module pc_next_sel
  import fetch_sequencer_pkg::*;
(
  input  logic [1:0]      i_op,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_target,
  input  logic [PC_W-1:0] i_stack,
  output logic [PC_W-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc + 16'd1;
    case (i_op)
      OP_CALL: o_pc_next = i_target;
      OP_RET:  o_pc_next = i_stack;
      default: o_pc_next = i_pc + 16'd1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-cycle FETCH/EXEC instruction sequencer with call/return PC control.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic [15:0]     imem_data,
  input  logic [16:0]     dataout_address_and_condition,
  input  logic [15:0]     stack_out,
  output logic [15:0]     imem_addr,
  output logic [15:0]     count_out,
  output logic [15:0]     ram8_out,
  output logic            instr_valid,
  output logic            busy
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_valid;
  logic            r_busy;
  logic [PC_W-1:0] w_pc_next;
  logic            w_unused_cond;

  // The condition bit only feeds the downstream stack push value.
  assign w_unused_cond = dataout_address_and_condition[16];

  pc_next_sel u_pc_next_sel (
    .i_op      ({r_ir[STORE_BIT], r_ir[FLOW_BIT]}),
    .i_pc      (r_pc),
    .i_target  (dataout_address_and_condition[15:0]),
    .i_stack   (stack_out),
    .o_pc_next (w_pc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_state <= EXEC;
          r_ir    <= imem_data;
          r_valid <= 1'b1;
        end
        EXEC: begin
          r_pc    <= w_pc_next;
          r_valid <= 1'b0;
          if (run) begin
            r_state <= FETCH;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign count_out   = r_pc;
  assign ram8_out    = r_ir;
  assign instr_valid = r_valid;
  assign busy        = r_busy;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have one clock and reset: clock `clk`, reset `reset_n`, asynchronous, active-low.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: run  input  1  level enable; 1 means sequence instructions, 0 means stop at the next FETCH boundary.
REQ-005 Port: imem_data  input  16  instruction word returned combinationally for address imem_addr.
REQ-006 Port: dataout_address_and_condition  input  17  [15:0] jump target, [16] condition bit.
REQ-007 Port: stack_out  input  16  return address from the call stack.
REQ-008 Port: imem_addr  output  16  instruction memory read address; equals count_out.
REQ-009 Port: count_out  output  16  program counter.
REQ-010 Port: ram8_out  output  16  instruction register feeding the execute slice.
REQ-011 Port: instr_valid  output  1  high for exactly the EXEC cycle; qualifies ram8_out.
REQ-012 Port: busy  output  1  high in FETCH or EXEC.

Function
REQ-013 FSM SHALL have the states IDLE, FETCH and EXEC.
REQ-014 IDLE SHALL go to FETCH when run=1 and SHALL otherwise stay in IDLE.
REQ-015 FETCH SHALL always go to EXEC after one cycle, capturing imem_data into ram8_out on that edge.
REQ-016 EXEC SHALL go to FETCH if run=1 and to IDLE if run=0; the PC update SHALL occur on the EXEC exit edge in both cases.
REQ-017 PC update SHALL be selected by ram8_out[15:14]:
- 2'b01 (call): count_out <= dataout_address_and_condition[15:0].
- 2'b11 (return): count_out <= stack_out.
- 2'b00 or 2'b10: count_out <= count_out + 1.
REQ-018 Increment SHALL be 16-bit modulo, so 16'hFFFF+1 = 16'h0000 with no flag.
REQ-019 The condition bit [16] SHALL NOT alter the PC; it is consumed downstream for the stack push value (count_out + cond).
REQ-020 ram8_out SHALL hold its value through FETCH and IDLE, change only on the FETCH-to-EXEC edge, and be sampled downstream only when instr_valid=1.
REQ-021 imem_addr SHALL equal count_out combinationally at all times.
REQ-022 A run deassertion during FETCH SHALL NOT abort it: EXEC SHALL complete, then the FSM SHALL go to IDLE.
REQ-023 Each instruction SHALL take exactly 2 cycles (FETCH+EXEC), so throughput is 1 instruction per 2 clocks.

Reset
REQ-024 While reset_n=0, the block SHALL set state=IDLE, count_out=16'h0000, ram8_out=16'h0000, instr_valid=0 and busy=0 immediately, independent of clk.
REQ-025 Reset asserted mid-EXEC SHALL discard the pending PC update.
REQ-026 First FETCH after reset release with run=1 SHALL read address 0.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/FETCH/EXEC) and the opcode-bit constants: STORE_BIT=15, FLOW_BIT=14, CORESEL_BIT=13, PC_W=16.
REQ-028 The block SHALL be a single module; the PC next-value mux MAY be split into a sub-module named pc_next_sel.
REQ-029 The instruction memory SHALL be external to this block.

Verification
REQ-030 Bench SHALL check reset: reset_n=0 mid-EXEC with PC=16'h0005 -> count_out=0, ram8_out=0, instr_valid=0 before the next clk edge.
REQ-031 Bench SHALL check sequential flow: run=1, imem words 16'h0001,16'h0002,16'h0003 -> count_out 0,1,2 and instr_valid pulses every 2nd cycle.
REQ-032 Bench SHALL check call: instruction 16'h4000 at PC=3 with target 16'h0100 -> next FETCH at 16'h0100.
REQ-033 Bench SHALL check return: instruction 16'hC000 with stack_out=16'h0004 -> next count_out=16'h0004.
REQ-034 Bench SHALL check wrap: PC=16'hFFFF with instruction 16'h0000 -> next count_out=16'h0000.
REQ-035 Bench SHALL check stop: run dropped during FETCH at PC=7 -> one EXEC completes, state=IDLE, count_out=8 held, busy=0.
